ddr_init_seq: RTL and testbench

//  Boot-time DDR init sequencer. Sits between the DDR4 controller path (calib_done,
//  AXI interconnect slave port) and the system core reset.

---
 rtl/ddr_init_seq.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ddr_init_seq
// Description : Boot-time DDR init sequencer. Waits for DDR calibration, fills
//               a DDR window with FILL_PATTERN over AXI4 INCR bursts (one burst
//               outstanding at a time), holds the system core in reset for
//               HOLD_CYCLES more cycles, then releases it.
//               Optional read-back verify is enabled by defining the macro
//               DDR_INIT_VERIFY_EN (adds AR/R channels and err_addr).
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_init_seq #(
    parameter int                    AXI_ID_W     = 4,
    parameter int                    AXI_ADDR_W   = 28,
    parameter int                    AXI_DATA_W   = 32,
    parameter logic [AXI_ADDR_W-1:0] INIT_BASE    = '0,
    parameter int                    INIT_WORDS   = 1024,
    parameter int                    BURST_LEN    = 16,
    parameter logic [AXI_DATA_W-1:0] FILL_PATTERN = '0,
    parameter int                    HOLD_CYCLES  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      calib_done,
    output logic                      sys_rst,
    output logic                      init_done,
    output logic                      init_err,
    output logic [AXI_ID_W-1:0]       m_axi_awid,
    output logic [AXI_ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_DATA_W-1:0]     m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [AXI_ID_W-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
`ifdef DDR_INIT_VERIFY_EN
    ,
    output logic [AXI_ID_W-1:0]       m_axi_arid,
    output logic [AXI_ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_W-1:0]       m_axi_rid,
    input  logic [AXI_DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_ADDR_W-1:0]     err_addr
`endif
);

    localparam int c_BEAT_BYTES  = AXI_DATA_W / 8;
    localparam int c_BURST_BYTES = BURST_LEN * c_BEAT_BYTES;
    localparam int c_NUM_BURSTS  = INIT_WORDS / BURST_LEN;
    localparam int c_BIDX_W      = (c_NUM_BURSTS > 1) ? $clog2(c_NUM_BURSTS) : 1;
    localparam int c_BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_BIDX_W-1:0] c_BIDX_LAST   = c_BIDX_W'(c_NUM_BURSTS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST   = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_PENULT = c_BEAT_W'((BURST_LEN > 1) ? BURST_LEN - 2 : 0);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST   = c_HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_HOLD = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t              r_state;
    logic                r_calib_meta;
    logic                r_calib_sync;
    logic                r_abort;
    logic [c_BIDX_W-1:0] r_bidx;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_sys_rst;
    logic                r_init_done;
    logic                r_init_err;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_wlast;
    logic                r_bready;
    logic                w_stop;
    logic [AXI_ADDR_W-1:0] w_burst_addr;
    logic                w_unused;

    // Burst address is derived from the burst index, which only changes while
    // no valid is asserted, so the payload is stable under backpressure.
    assign w_burst_addr = INIT_BASE
                        + AXI_ADDR_W'(r_bidx) * AXI_ADDR_W'(c_BURST_BYTES);
    // Calibration lost now or earlier in this burst: finish it, then go idle.
    assign w_stop       = r_abort | ~r_calib_sync;

    assign sys_rst       = r_sys_rst;
    assign init_done     = r_init_done;
    assign init_err      = r_init_err;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = w_burst_addr;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(c_BEAT_BYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = FILL_PATTERN;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = r_wlast;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

`ifdef DDR_INIT_VERIFY_EN
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_verr;
    logic [AXI_ADDR_W-1:0] r_err_addr;
    logic                  w_rbeat_bad;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = w_burst_addr;
    assign m_axi_arlen   = m_axi_awlen;
    assign m_axi_arsize  = m_axi_awsize;
    assign m_axi_arburst = m_axi_awburst;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign err_addr      = r_err_addr;
    // A read beat fails on wrong data, error response, or rlast misplaced.
    assign w_rbeat_bad   = (m_axi_rdata != FILL_PATTERN) || (m_axi_rresp != 2'b00)
                        || (m_axi_rlast != (r_beat == c_BEAT_LAST));
    assign w_unused      = ^{m_axi_bid, m_axi_rid};
`else
    assign w_unused      = ^m_axi_bid;
`endif

    // Two-flop synchroniser for the asynchronous calibration flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_calib_meta <= 1'b0;
            r_calib_sync <= 1'b0;
        end else begin
            r_calib_meta <= calib_done;
            r_calib_sync <= r_calib_meta;
        end
    end

    // Init sequencer: fill bursts, optional read-back, hold, then release reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_abort     <= 1'b0;
            r_bidx      <= '0;
            r_beat      <= '0;
            r_hold      <= '0;
            r_sys_rst   <= 1'b1;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
`ifdef DDR_INIT_VERIFY_EN
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_verr      <= 1'b0;
            r_err_addr  <= '0;
`endif
        end else begin
            if (!r_calib_sync) r_abort <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (r_calib_sync) begin
                        r_state   <= S_AW;
                        r_awvalid <= 1'b1;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (BURST_LEN == 1);
                        r_beat    <= '0;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (m_axi_wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_B;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_wlast <= (r_beat == c_BEAT_PENULT);
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) r_init_err <= 1'b1;
                        if (w_stop) begin
                            r_bidx  <= '0;
                            r_state <= S_IDLE;
                        end else if (r_bidx == c_BIDX_LAST) begin
`ifdef DDR_INIT_VERIFY_EN
                            r_bidx    <= '0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
`else
                            r_hold  <= '0;
                            r_state <= S_HOLD;
`endif
                        end else begin
                            r_bidx    <= r_bidx + 1'b1;
                            r_awvalid <= 1'b1;
                            r_state   <= S_AW;
                        end
                    end
                end
`ifdef DDR_INIT_VERIFY_EN
                S_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (m_axi_rvalid) begin
                        if (w_rbeat_bad) begin
                            r_init_err <= 1'b1;
                            if (!r_verr) begin
                                r_verr     <= 1'b1;
                                r_err_addr <= w_burst_addr
                                            + AXI_ADDR_W'(r_beat) * AXI_ADDR_W'(c_BEAT_BYTES);
                            end
                        end
                        if (r_beat == c_BEAT_LAST) begin
                            r_rready <= 1'b0;
                            if (w_stop) begin
                                r_bidx  <= '0;
                                r_state <= S_IDLE;
                            end else if (r_bidx == c_BIDX_LAST) begin
                                r_hold  <= '0;
                                r_state <= S_HOLD;
                            end else begin
                                r_bidx    <= r_bidx + 1'b1;
                                r_arvalid <= 1'b1;
                                r_state   <= S_AR;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
`endif
                S_HOLD: begin
                    if (!r_calib_sync) begin
                        r_bidx  <= '0;
                        r_state <= S_IDLE;
                    end else if (r_hold == c_HOLD_LAST) begin
                        r_sys_rst   <= 1'b0;
                        r_init_done <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_init_seq
// Description : Self-checking bench for ddr_init_seq. A randomly stalling AXI
//               slave drives the DUT; expected burst addresses are queued by
//               the stimulus and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_init_seq;

    localparam int          ID_W   = 4;
    localparam int          ADDR_W = 28;
    localparam int          DATA_W = 32;
    localparam int          BASE   = 0;
    localparam int          WORDS  = 32;
    localparam int          BL     = 16;
    localparam int          HOLD   = 16;
    localparam int          NB     = WORDS / BL;
    localparam int          BBYTES = BL * DATA_W / 8;
    localparam logic [DATA_W-1:0] FILL = 32'hC0DE_F00D;

    logic clk = 1'b0;
    logic rst, calib_done;
    logic sys_rst, init_done, init_err;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize, awprot;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache, awqos;
    logic              awvalid, awready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast, wvalid, wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid, bready;
`ifdef DDR_INIT_VERIFY_EN
    logic [ID_W-1:0]   arid, rid;
    logic [ADDR_W-1:0] araddr, err_addr;
    logic [7:0]        arlen;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst, rresp;
    logic              arlock;
    logic [3:0]        arcache, arqos;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic              rlast, rvalid, rready;
`endif

    always #5 clk = ~clk;

    ddr_init_seq #(
        .AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W),
        .INIT_BASE(ADDR_W'(BASE)), .INIT_WORDS(WORDS), .BURST_LEN(BL),
        .FILL_PATTERN(FILL), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .calib_done(calib_done),
        .sys_rst(sys_rst), .init_done(init_done), .init_err(init_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
`ifdef DDR_INIT_VERIFY_EN
        ,
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .err_addr(err_addr)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Scoreboard of expected AW addresses, filled by the stimulus.
    logic [ADDR_W-1:0] exp_aw[$];

    // Slave configuration and state.
    int stall_max   = 0;
    int bad_b_burst = -1;
    int bad_r_burst = -1;
    int b_count     = 0;
    int r_burst     = 0;

    // Monitor state.
    int mon_b        = 0;
    int mon_aw_total = 0;
    int mon_ar       = 0;
    int last_end_cyc = -1;
    int fall_cyc     = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rnd_wait();
        return (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // AXI slave: decides readies/valids on the falling edge for the next rising edge.
    initial begin : slave
        int  aw_wait, w_wait, b_wait, b_due;
        bit  aw_fire, w_fire, w_fire_last, b_fire;
`ifdef DDR_INIT_VERIFY_EN
        int  ar_wait, r_pending, r_beat;
        bit  ar_fire, r_fire;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = '0;
        ar_wait = -1; r_pending = 0; r_beat = 0; ar_fire = 0; r_fire = 0;
`endif
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
        aw_wait = -1; w_wait = -1; b_wait = -1; b_due = 0;
        aw_fire = 0; w_fire = 0; w_fire_last = 0; b_fire = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0;
                aw_wait = -1; w_wait = -1; b_wait = -1; b_due = 0;
                aw_fire = 0; w_fire = 0; w_fire_last = 0; b_fire = 0;
`ifdef DDR_INIT_VERIFY_EN
                arready = 0; rvalid = 0; ar_wait = -1; r_pending = 0; r_beat = 0;
                ar_fire = 0; r_fire = 0;
`endif
                continue;
            end
            // Retire handshakes completed at the last rising edge.
            if (b_fire) begin
                bvalid = 0;
                b_count++;
            end
            if (w_fire && w_fire_last) b_due++;
            // AW channel
            awready = 0;
            if (awvalid) begin
                if (aw_wait < 0) aw_wait = rnd_wait();
                if (aw_wait == 0) begin awready = 1; aw_wait = -1; end
                else aw_wait--;
            end
            // W channel
            wready = 0;
            if (wvalid) begin
                if (w_wait < 0) w_wait = rnd_wait();
                if (w_wait == 0) begin wready = 1; w_wait = -1; end
                else w_wait--;
            end
            // B channel
            if (b_due > 0 && !bvalid) begin
                if (b_wait < 0) b_wait = rnd_wait();
                if (b_wait == 0) begin
                    bvalid = 1;
                    bresp  = (b_count == bad_b_burst) ? 2'b10 : 2'b00;
                    b_due--;
                    b_wait = -1;
                end else b_wait--;
            end
`ifdef DDR_INIT_VERIFY_EN
            if (ar_fire) r_pending++;
            if (r_fire) begin
                r_beat++;
                if (r_beat == BL) begin r_beat = 0; r_pending--; r_burst++; end
            end
            arready = 0;
            if (arvalid) begin
                if (ar_wait < 0) ar_wait = rnd_wait();
                if (ar_wait == 0) begin arready = 1; ar_wait = -1; end
                else ar_wait--;
            end
            rvalid = 0;
            if (r_pending > 0) begin
                rvalid = 1;
                rdata  = (r_burst == bad_r_burst && r_beat == 5) ? ~FILL : FILL;
                rresp  = 2'b00;
                rlast  = (r_beat == BL - 1);
            end
            ar_fire = arvalid && arready;
            r_fire  = rvalid && rready;
`endif
            aw_fire     = awvalid && awready;
            w_fire      = wvalid && wready;
            w_fire_last = wlast;
            b_fire      = bvalid && bready;
        end
    end

    // Monitor: observes handshakes just after the slave settles its inputs.
    initial begin : monitor
        bit                 aw_hold, w_hold, prev_awvalid, prev_sys_rst;
        logic [ADDR_W-1:0]  aw_prev;
        logic [DATA_W+DATA_W/8:0] w_prev;
        int                 beat, outstanding;
        aw_hold = 0; w_hold = 0; prev_awvalid = 0; prev_sys_rst = 1;
        aw_prev = '0; w_prev = '0; beat = 0; outstanding = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                aw_hold = 0; w_hold = 0; prev_awvalid = 0; prev_sys_rst = 1;
                beat = 0; outstanding = 0;
                continue;
            end
            if (aw_hold) check("aw_stable", awaddr, aw_prev);
            if (awvalid && !prev_awvalid) check("aw_one_outstanding", outstanding, 0);
            if (awvalid && awready) begin
                check("aw_expected", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0) check("awaddr", awaddr, exp_aw.pop_front());
                check("aw_const", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos},
                      {4'h0, 8'd15, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
                outstanding++;
                mon_aw_total++;
            end
            aw_hold      = awvalid && !awready;
            aw_prev      = awaddr;
            prev_awvalid = awvalid;

            if (w_hold) check("w_stable", {wdata, wstrb, wlast}, w_prev);
            if (wvalid && wready) begin
                check("wdata_wstrb", {wdata, wstrb}, {FILL, 4'hF});
                check("wlast_pos", wlast, beat == BL - 1);
                beat++;
                if (wlast) begin
                    check("beats_per_burst", beat, BL);
                    beat = 0;
                end
            end
            w_hold = wvalid && !wready;
            w_prev = {wdata, wstrb, wlast};

            if (bvalid && bready) begin
                outstanding--;
                mon_b++;
                last_end_cyc = cyc + 1;
            end
`ifdef DDR_INIT_VERIFY_EN
            if (arvalid && arready) begin
                check("araddr", araddr, ADDR_W'(BASE + mon_ar * BBYTES));
                check("ar_const", {arlen, arsize, arburst}, {8'd15, 3'd2, 2'b01});
                mon_ar++;
            end
            if (rvalid && rready && rlast) last_end_cyc = cyc + 1;
`endif
            if (!sys_rst && prev_sys_rst) fall_cyc = cyc;
            prev_sys_rst = sys_rst;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        rst = 1; calib_done = 0;
        step(3);
`ifdef DDR_INIT_VERIFY_EN
        check({tag, "_reset_state"}, {sys_rst, init_done, init_err, awvalid, wvalid, bready, arvalid, rready},
              8'b1000_0000);
`else
        check({tag, "_reset_state"}, {sys_rst, init_done, init_err, awvalid, wvalid, bready}, 6'b100000);
`endif
        exp_aw.delete();
        rst = 0;
        step(1);
    endtask

    task automatic push_expected();
        for (int i = 0; i < NB; i++) exp_aw.push_back(ADDR_W'(BASE + i * BBYTES));
    endtask

    task automatic wait_done_and_check(input string tag, input bit exp_err);
        int n = 0;
        while (!init_done && n < 4000) begin step(1); n++; end
        check({tag, "_init_done"}, init_done, 1);
        step(2);
        check({tag, "_sys_rst_low"}, sys_rst, 0);
        check({tag, "_init_err"}, init_err, exp_err);
        check({tag, "_aw_all_seen"}, exp_aw.size(), 0);
        check({tag, "_b_count"}, mon_b, NB);
        check({tag, "_hold_cycles"}, fall_cyc - last_end_cyc, HOLD);
    endtask

    task automatic run_fill(input string tag, input int smax, input int bad_b,
                            input int bad_r, input bit exp_err);
        stall_max = smax; bad_b_burst = bad_b; bad_r_burst = bad_r;
        b_count = 0; r_burst = 0; mon_ar = 0; mon_b = 0;
        last_end_cyc = -1; fall_cyc = -1;
        push_expected();
        calib_done = 1;
        wait_done_and_check(tag, exp_err);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        rst = 1; calib_done = 0;

        // T1: clean fill, slave always ready.
        do_reset("t1");
        check("t1_sys_rst_before_calib", sys_rst, 1);
        run_fill("t1", 0, -1, -1, 0);

        // T2: random stalls on all channels.
        do_reset("t2");
        run_fill("t2", 5, -1, -1, 0);

        // T3: error response on burst 0 is sticky but the fill completes.
        do_reset("t3");
        run_fill("t3", 2, 0, -1, 1);
        step(5);
        check("t3_err_sticky", init_err, 1);

        // T4: calibration drops during W of burst 1.
        do_reset("t4");
        check("t4_err_cleared", init_err, 0);
        stall_max = 0; bad_b_burst = -1; bad_r_burst = -1;
        b_count = 0; r_burst = 0; mon_ar = 0; mon_b = 0; mon_aw_total = 0;
        push_expected();
        calib_done = 1;
        n = 0;
        while (!(mon_aw_total == 2 && wvalid) && n < 500) begin step(1); n++; end
        check("t4_reached_burst1_w", mon_aw_total == 2 && wvalid, 1);
        step(3);
        calib_done = 0;
        n = 0;
        while (mon_b < 2 && n < 500) begin step(1); n++; end
        check("t4_burst1_completed", mon_b, 2);
        step(20);
        check("t4_idle_state", {awvalid, wvalid, sys_rst, init_done}, 4'b0010);
        check("t4_no_extra_bursts", mon_aw_total, 2);
        mon_b = 0; mon_ar = 0; r_burst = 0; b_count = 0;
        last_end_cyc = -1; fall_cyc = -1;
        push_expected();
        calib_done = 1;
        wait_done_and_check("t4", 0);
        calib_done = 0;
        step(10);
        check("t4_done_terminal", {sys_rst, init_done}, 2'b01);

        // T5: reset pulse in the middle of a W burst.
        do_reset("t5");
        stall_max = 1; bad_b_burst = -1; bad_r_burst = -1;
        push_expected();
        calib_done = 1;
        n = 0;
        while (!wvalid && n < 500) begin step(1); n++; end
        check("t5_reached_w", wvalid, 1);
        step(2);
        rst = 1;
        @(negedge clk);
        #1;
        check("t5_async_reset", {awvalid, wvalid, bready, sys_rst, init_done}, 5'b00010);
        exp_aw.delete();
        step(3);
        rst = 0;
        run_fill("t5", 0, -1, -1, 0);

`ifdef DDR_INIT_VERIFY_EN
        // T6: read-back corruption on beat 5 of burst 1.
        do_reset("t6");
        run_fill("t6", 0, -1, 1, 1);
        check("t6_err_addr", err_addr, ADDR_W'(BASE + 32'h54));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
